alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Initiator-side front end for the 8-bit combinational ALU: accepts operation commands over a valid/ready stream, drives the ALU operand/opcode inputs from a registered issue stage, captures the ALU result and returns it, tagged, over a valid/ready result stream.
- Sits between the command source (sequencer or bench) and the ALU.
- Buffers results so downstream backpressure never corrupts an in-flight operation.

Parameters:
- DEPTH, 4, result FIFO entries (power of 2, >=2)
- TAG_W, 4, width of the command tag carried to the result

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  command accepted when valid&&ready
- cmd_a_i  input  8  operand a
- cmd_b_i  input  8  operand b
- cmd_op_i  input  3  opcode (000 ADD, 001 SUB, 010 SLL, 011 LSR, 100 AND, 101 OR, 110 XOR, 111 EQL)
- cmd_tag_i  input  TAG_W  command tag
- alu_a_o  output  8  to ALU a input
- alu_b_o  output  8  to ALU b input
- alu_op_o  output  3  to ALU opcode
- alu_res_i  input  8  ALU result (combinational from alu_*_o)
- res_valid_o  output  1  result valid
- res_ready_i  input  1  result consumed when valid&&ready
- res_data_o  output  8  result value
- res_tag_o  output  TAG_W  tag of the originating command
- res_zero_o  output  1  res_data_o == 0
- flush_i  input  1  discard all in-flight and buffered operations
- issued_cnt_o  output  16  saturating count of accepted commands

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - cmd_ready_o=1 after reset
  - alu_a_o=alu_b_o=0, alu_op_o=000
  - res_valid_o=0, res_data_o=0, res_tag_o=0, res_zero_o=0
  - issued_cnt_o=0
  - FIFO empty, issue stage empty
- Issue stage: register (issue_v, a, b, op, tag).
  - On accept, load the command; issue_v=1 for exactly one cycle.
  - alu_*_o are driven directly from the issue registers and hold their last value when issue_v=0.
- Capture: in any cycle with issue_v=1, push {alu_res_i, tag} into the FIFO.
  - Latency: accept at edge N -> issue at N+1 -> res_valid_o at N+2 if the FIFO was empty.
- Throughput: one command per cycle while space remains.
- Credit rule: cmd_ready_o = (fifo_count + issue_v) < DEPTH.
  - Combinational from registered state only; no dependence on res_ready_i.
  - Guarantees a capture never hits a full FIFO. A push while full is impossible by construction; flag it with an assertion.
- FIFO: first-word-fall-through; res_data_o/res_tag_o show the head entry.
  - res_zero_o = (res_data_o==0) && res_valid_o.
  - Simultaneous push and pop when non-empty: count unchanged, order preserved.
  - Pointers wrap modulo DEPTH.
- EQL results pass through unmodified (ALU supplies 0x00/0x01).
- flush_i (sync, priority below reset, above everything else):
  - Next cycle: FIFO empty, issue_v=0, res_valid_o=0.
  - A command presented in the flush cycle is not accepted (cmd_ready_o forced 0 that cycle).
  - issued_cnt_o is not cleared.
- issued_cnt_o: +1 per accepted command; saturates at 0xFFFF.
- Reset mid-operation: all in-flight and buffered results are dropped; no res_valid_o pulse after reset.
- Control FSM: two states on issue_v.
  - IDLE -> ISSUE on accept.
  - ISSUE -> ISSUE on accept, else IDLE.
  - Any state -> IDLE on flush or reset.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (ADD..EQL, 3 bits)
  - typedef alu_cmd_t {a, b, op, tag}
  - typedef alu_res_t {data, tag}
- Sub-module: alu_res_fifo (parameterised sync FWFT FIFO of alu_res_t with count output and flush).
- Bench instantiates the existing ALU between alu_*_o and alu_res_i.

Test Plan:
- Single ADD a=0x05 b=0x03 tag=1, res_ready_i=1 -> res_valid_o high 2 cycles after accept, res_data_o=0x08, res_tag_o=1, res_zero_o=0.
- Back-to-back SUB 0x10-0x10, SLL 0x81<<1, LSR 0x80>>7, EQL 0x5A/0x5A -> results in order: 0x00 (res_zero_o=1), 0x02, 0x01, 0x01; one per cycle.
- res_ready_i=0, stream 6 commands -> exactly DEPTH(4) accepted, cmd_ready_o=0 after the 4th. Release ready -> results drain in tag order, the remaining 2 are accepted.
- Push and pop in the same cycle with 2 entries buffered -> count stays 2, no loss or duplication.
- Assert flush_i with 3 buffered plus 1 issuing -> next cycle res_valid_o=0, cmd_ready_o=1, issued_cnt_o unchanged.
- Preload issued_cnt_o to 0xFFFE via 3 accepts past it -> holds at 0xFFFF. Reset mid-stream -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the 8-bit ALU command front end: opcodes, command and result records.
package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_TAG_W  = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SLL = 3'b010,
    OP_LSR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    alu_op_e               op;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_res_t;

endpackage

// File: rtl/alu_res_fifo.sv
// Synchronous first-word-fall-through FIFO of ALU results with occupancy count and flush.
module alu_res_fifo
  import alu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  alu_res_t      wdata_i,
  output alu_res_t      rdata_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  alu_res_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // The upstream credit check makes this unreachable.
  always_ff @(posedge clk) begin
    if (!reset && !flush_i) begin
      assert (!(push_i && count_q == CW'(DEPTH)));
    end
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Command front end for the combinational ALU: registered issue stage, result capture
// into a credit-protected FWFT FIFO, tagged valid/ready result stream.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [7:0]       cmd_a_i,
  input  logic [7:0]       cmd_b_i,
  input  logic [2:0]       cmd_op_i,
  input  logic [TAG_W-1:0] cmd_tag_i,
  output logic [7:0]       alu_a_o,
  output logic [7:0]       alu_b_o,
  output logic [2:0]       alu_op_o,
  input  logic [7:0]       alu_res_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [7:0]       res_data_o,
  output logic [TAG_W-1:0] res_tag_o,
  output logic             res_zero_o,
  input  logic             flush_i,
  output logic [15:0]      issued_cnt_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e        state_q, state_d;
  logic          issue_v;
  alu_cmd_t      issue_q, issue_d;
  logic [15:0]   issued_cnt_q, issued_cnt_d;
  logic          accept;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          fifo_empty;
  alu_res_t      fifo_head, fifo_wdata;

  // Tags ride at package width; TAG_W must not exceed ALU_TAG_W.
  assign credit_used = {1'b0, fifo_count} + (CW+1)'(issue_v);
  assign cmd_ready_o = !flush_i && (credit_used < (CW+1)'(DEPTH));
  assign accept      = cmd_valid_i && cmd_ready_o;

  always_ff @(posedge clk) begin
    if (reset || flush_i) state_q <= S_IDLE;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_ISSUE;
      S_ISSUE: state_d = accept ? S_ISSUE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    issue_v = (state_q == S_ISSUE);
  end

  always_comb begin
    issue_d      = issue_q;
    issued_cnt_d = issued_cnt_q;
    if (accept) begin
      issue_d.a   = cmd_a_i;
      issue_d.b   = cmd_b_i;
      issue_d.op  = alu_op_e'(cmd_op_i);
      issue_d.tag = ALU_TAG_W'(cmd_tag_i);
      if (issued_cnt_q != 16'hFFFF) issued_cnt_d = issued_cnt_q + 16'd1;
    end
  end

  // Issue stage: operands hold their last value between commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      issue_q      <= '0;
      issued_cnt_q <= '0;
    end else begin
      issue_q      <= issue_d;
      issued_cnt_q <= issued_cnt_d;
    end
  end

  assign alu_a_o      = issue_q.a;
  assign alu_b_o      = issue_q.b;
  assign alu_op_o     = issue_q.op;
  assign issued_cnt_o = issued_cnt_q;

  // Capture stage: the ALU result is pushed while the issue stage is live.
  assign fifo_wdata.data = alu_res_i;
  assign fifo_wdata.tag  = issue_q.tag;

  alu_res_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .push_i  (issue_v),
    .pop_i   (res_ready_i),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign res_valid_o = !fifo_empty;
  assign res_data_o  = res_valid_o ? fifo_head.data : 8'h00;
  assign res_tag_o   = res_valid_o ? TAG_W'(fifo_head.tag) : '0;
  assign res_zero_o  = res_valid_o && (fifo_head.data == 8'h00);

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a behavioural ALU between the issue and capture ports.
module tb_alu_cmd_driver;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready_o;
  logic [7:0]       cmd_a, cmd_b;
  logic [2:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;
  logic [7:0]       alu_a_o, alu_b_o, alu_res;
  logic [2:0]       alu_op_o;
  logic             res_valid_o, res_ready, res_zero_o, flush;
  logic [7:0]       res_data_o;
  logic [TAG_W-1:0] res_tag_o;
  logic [15:0]      issued_cnt_o;

  always #5 clk = ~clk;

  alu_cmd_driver #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_a_i      (cmd_a),
    .cmd_b_i      (cmd_b),
    .cmd_op_i     (cmd_op),
    .cmd_tag_i    (cmd_tag),
    .alu_a_o      (alu_a_o),
    .alu_b_o      (alu_b_o),
    .alu_op_o     (alu_op_o),
    .alu_res_i    (alu_res),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready),
    .res_data_o   (res_data_o),
    .res_tag_o    (res_tag_o),
    .res_zero_o   (res_zero_o),
    .flush_i      (flush),
    .issued_cnt_o (issued_cnt_o)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a << b[2:0];
      3'd3:    return a >> b[2:0];
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return (a == b) ? 8'd1 : 8'd0;
    endcase
  endfunction

  always_comb alu_res = alu_f(alu_a_o, alu_b_o, alu_op_o);

  typedef struct packed {
    logic [7:0]       data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic bp_done;

  logic [7:0] bp_a   [6] = '{8'h01, 8'hFF, 8'h0F, 8'hAA, 8'h3C, 8'h00};
  logic [7:0] bp_b   [6] = '{8'h02, 8'h01, 8'hF0, 8'h0F, 8'hFF, 8'h01};
  logic [2:0] bp_op  [6] = '{3'd0, 3'd0, 3'd5, 3'd4, 3'd6, 3'd1};
  logic [7:0] bp_exp [6] = '{8'h03, 8'h00, 8'hFF, 8'h0A, 8'hC3, 8'hFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (res_valid_o && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got tag %0d data 0x%0h, required no result",
                 res_tag_o, res_data_o);
      end else begin
        e = sb.pop_front();
        chk("res_data", {24'd0, res_data_o}, {24'd0, e.data});
        chk("res_tag",  {28'd0, res_tag_o},  {28'd0, e.tag});
        chk("res_zero", {31'd0, res_zero_o}, {31'd0, (e.data == 8'h00)});
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                      input logic [TAG_W-1:0] tag, input logic [7:0] exp);
    int n = 0;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: tag %0d got no ready within 100 cycles, required accept", tag);
    end else begin
      sb.push_back(exp_t'{data: exp, tag: tag});
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tagname);
    chk({tagname, "_cmd_ready"}, {31'd0, cmd_ready_o}, 32'd1);
    chk({tagname, "_alu_a"},     {24'd0, alu_a_o}, 32'd0);
    chk({tagname, "_alu_b"},     {24'd0, alu_b_o}, 32'd0);
    chk({tagname, "_alu_op"},    {29'd0, alu_op_o}, 32'd0);
    chk({tagname, "_res_valid"}, {31'd0, res_valid_o}, 32'd0);
    chk({tagname, "_res_data"},  {24'd0, res_data_o}, 32'd0);
    chk({tagname, "_res_tag"},   {28'd0, res_tag_o}, 32'd0);
    chk({tagname, "_res_zero"},  {31'd0, res_zero_o}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] cnt0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    res_ready = 1'b1; flush = 1'b0; bp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_state("rst");
    chk("rst_issued_cnt", {16'd0, issued_cnt_o}, 32'd0);
    @(posedge clk); #1;

    // Single ADD: result two cycles after the accept edge.
    send(8'h05, 8'h03, 3'd0, 4'd1, 8'h08);
    @(negedge clk);
    chk("lat_issue_no_valid", {31'd0, res_valid_o}, 32'd0);
    chk("lat_alu_a", {24'd0, alu_a_o}, 32'h05);
    @(negedge clk);
    chk("lat_res_valid", {31'd0, res_valid_o}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back commands, one result per cycle.
    send(8'h10, 8'h10, 3'd1, 4'd2, 8'h00);
    send(8'h81, 8'h01, 3'd2, 4'd3, 8'h02);
    send(8'h80, 8'h07, 3'd3, 4'd4, 8'h01);
    send(8'h5A, 8'h5A, 3'd7, 4'd5, 8'h01);
    repeat (2) @(negedge clk);
    #1 chk("b2b_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Backpressure: only DEPTH commands get in while results are stalled.
    res_ready = 1'b0;
    cnt0 = issued_cnt_o;
    fork
      begin
        for (int i = 0; i < 6; i++) send(bp_a[i], bp_b[i], bp_op[i], TAG_W'(6 + i), bp_exp[i]);
        bp_done = 1'b1;
      end
    join_none
    repeat (8) @(negedge clk);
    chk("bp_ready_low", {31'd0, cmd_ready_o}, 32'd0);
    chk("bp_accepted_4", {16'd0, issued_cnt_o - cnt0}, 32'd4);
    chk("bp_head_tag", {28'd0, res_tag_o}, 32'd6);
    @(posedge clk); #1 res_ready = 1'b1;
    for (int i = 0; i < 50 && !bp_done; i++) @(negedge clk);
    chk("bp_sender_done", {31'd0, bp_done}, 32'd1);
    repeat (4) @(negedge clk);
    #1 chk("bp_drained", sb.size(), 32'd0);
    chk("bp_accepted_6", {16'd0, issued_cnt_o - cnt0}, 32'd6);
    @(posedge clk); #1;

    // Push and pop in the same cycle with two entries buffered.
    res_ready = 1'b0;
    send(8'h01, 8'h01, 3'd0, 4'd12, 8'h02);
    send(8'h02, 8'h02, 3'd0, 4'd13, 8'h04);
    send(8'h03, 8'h03, 3'd0, 4'd14, 8'h06);
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 chk("pp_count_held", {{(32-$clog2(DEPTH)-1){1'b0}}, dut.fifo_count}, 32'd2);
    repeat (3) @(negedge clk);
    #1 chk("pp_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Flush with three buffered and one issuing.
    res_ready = 1'b0;
    send(8'h11, 8'h22, 3'd0, 4'd1, 8'h33);
    send(8'h44, 8'h11, 3'd1, 4'd2, 8'h33);
    send(8'hF0, 8'h0F, 3'd5, 4'd3, 8'hFF);
    send(8'h01, 8'h03, 3'd2, 4'd4, 8'h08);
    cnt0 = issued_cnt_o;
    flush = 1'b1;
    cmd_a = 8'h09; cmd_b = 8'h09; cmd_op = 3'd0; cmd_tag = 4'd9; cmd_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_res_valid", {31'd0, res_valid_o}, 32'd0);
    chk("flush_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    chk("flush_cnt_kept", {16'd0, issued_cnt_o}, {16'd0, cnt0});
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("flush_no_stale", {31'd0, res_valid_o}, 32'd0);
    // Flush with credit available still blocks the presented command.
    @(posedge clk); #1;
    flush = 1'b1; cmd_valid = 1'b1;
    @(negedge clk);
    chk("flush_ready_forced", {31'd0, cmd_ready_o}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("flush_cmd_dropped", {16'd0, issued_cnt_o}, {16'd0, cnt0});
    chk("flush_cmd_no_result", {31'd0, res_valid_o}, 32'd0);
    @(posedge clk); #1;
    send(8'h02, 8'h02, 3'd0, 4'd7, 8'h04);
    repeat (3) @(negedge clk);
    #1 chk("post_flush_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Counter saturation from a preloaded 0xFFFE.
    force dut.issued_cnt_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.issued_cnt_q;
    @(negedge clk);
    chk("sat_preload", {16'd0, issued_cnt_o}, 32'hFFFE);
    @(posedge clk); #1;
    send(8'h01, 8'h00, 3'd0, 4'd1, 8'h01);
    chk("sat_reach", {16'd0, issued_cnt_o}, 32'hFFFF);
    send(8'h02, 8'h00, 3'd0, 4'd2, 8'h02);
    send(8'h03, 8'h00, 3'd0, 4'd3, 8'h03);
    @(negedge clk);
    chk("sat_hold", {16'd0, issued_cnt_o}, 32'hFFFF);
    repeat (3) @(negedge clk);
    #1 chk("sat_drained", sb.size(), 32'd0);
    @(posedge clk); #1;

    // Reset mid-stream drops everything in flight.
    res_ready = 1'b0;
    send(8'h07, 8'h01, 3'd0, 4'd5, 8'h08);
    send(8'h07, 8'h02, 3'd0, 4'd6, 8'h09);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state("midrst");
    chk("midrst_issued_cnt", {16'd0, issued_cnt_o}, 32'd0);
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_no_pulse", {31'd0, res_valid_o}, 32'd0);

    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
